// File: rtl/control_fsm_param_if.sv
// Control bundle between the CPU controller FSM and its datapath.
// master = controller side, slave = datapath side.
interface control_fsm_param_if #(
  parameter int IW   = 16,
  parameter int OPW  = 4,
  parameter int RAW  = 4,
  parameter int DAW  = 8,
  parameter int ALUW = 3
);
  logic [IW-1:0]   IR;
  logic            Run;
  logic            Ra_zero;
  logic            PC_clr;
  logic            PC_up;
  logic            PC_ld;
  logic [DAW-1:0]  PC_addr;
  logic            IR_ld;
  logic [DAW-1:0]  D_addr;
  logic            D_wr;
  logic [1:0]      RF_s;
  logic            RF_W_en;
  logic [RAW-1:0]  RF_W_addr;
  logic [RAW-1:0]  RF_Ra_addr;
  logic [RAW-1:0]  RF_Rb_addr;
  logic [ALUW-1:0] Alu_s;
  logic [DAW-1:0]  Imm;
  logic            Halted;
  logic            Illegal;
  logic [3:0]      CurrentState;

  modport master (
    input  IR, Run, Ra_zero,
    output PC_clr, PC_up, PC_ld, PC_addr, IR_ld,
    output D_addr, D_wr, RF_s, RF_W_en,
    output RF_W_addr, RF_Ra_addr, RF_Rb_addr,
    output Alu_s, Imm, Halted, Illegal,
    output CurrentState
  );

  modport slave (
    output IR, Run, Ra_zero,
    input  PC_clr, PC_up, PC_ld, PC_addr, IR_ld,
    input  D_addr, D_wr, RF_s, RF_W_en,
    input  RF_W_addr, RF_Ra_addr, RF_Rb_addr,
    input  Alu_s, Imm, Halted, Illegal,
    input  CurrentState
  );
endinterface

// File: rtl/control_fsm_param.sv
// Parametrised CPU control FSM: fetch/decode/execute sequencing with
// multi-cycle loads, load-immediate, jump-if-zero and resumable halt.
module control_fsm_param #(
  parameter int IW      = 16,
  parameter int OPW     = 4,
  parameter int RAW     = 4,
  parameter int DAW     = 8,
  parameter int ALUW    = 3,
  parameter int MEM_LAT = 1
) (
  input  logic Clk,
  input  logic ResetN,
  control_fsm_param_if.master bus
);

  localparam logic [3:0] S_INIT  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_DEC   = 4'd2;
  localparam logic [3:0] S_NOOP  = 4'd3;
  localparam logic [3:0] S_STORE = 4'd4;
  localparam logic [3:0] S_LDW   = 4'd5;
  localparam logic [3:0] S_LDWR  = 4'd6;
  localparam logic [3:0] S_ALU   = 4'd7;
  localparam logic [3:0] S_LDI   = 4'd8;
  localparam logic [3:0] S_JPZ   = 4'd9;
  localparam logic [3:0] S_HALT  = 4'd10;

  localparam logic [OPW-1:0] OP_NOOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_STORE = OPW'(1);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(5);
  localparam logic [OPW-1:0] OP_LDI   = OPW'(6);
  localparam logic [OPW-1:0] OP_JPZ   = OPW'(7);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  logic [3:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ill_q, ill_d;
  logic [OPW-1:0] op_q, op_d;

  logic [OPW-1:0] f_op;
  logic [RAW-1:0] f_a, f_b, f_w;
  logic [DAW-1:0] f_hi, f_lo;

  assign f_op = bus.IR[IW-1 -: OPW];
  assign f_a  = bus.IR[IW-OPW-1 -: RAW];
  assign f_b  = bus.IR[IW-OPW-RAW-1 -: RAW];
  assign f_w  = bus.IR[RAW-1:0];
  assign f_hi = bus.IR[IW-OPW-1 -: DAW];
  assign f_lo = bus.IR[DAW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    op_d    = op_q;
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: state_d = S_DEC;
      S_DEC: begin
        op_d = f_op;
        case (f_op)
          OP_NOOP:  state_d = S_NOOP;
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LDW;
          OP_ADD:   state_d = S_ALU;
          OP_SUB:   state_d = S_ALU;
          OP_HALT:  state_d = S_HALT;
          OP_LDI:   state_d = S_LDI;
          OP_JPZ:   state_d = S_JPZ;
          default: begin
            state_d = S_HALT;
            ill_d   = 1'b1;
          end
        endcase
      end
      S_NOOP, S_STORE, S_LDWR,
      S_ALU, S_LDI, S_JPZ: state_d = S_FETCH;
      S_LDW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_LDWR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HALT: if (bus.Run) state_d = S_FETCH;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.PC_ld      = 1'b0;
    bus.PC_addr    = '0;
    bus.IR_ld      = 1'b0;
    bus.D_addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 2'd0;
    bus.RF_W_en    = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.Alu_s      = '0;
    bus.Imm        = '0;
    bus.Halted     = 1'b0;
    case (state_q)
      S_INIT: bus.PC_clr = 1'b1;
      S_FETCH: begin
        bus.IR_ld = 1'b1;
        bus.PC_up = 1'b1;
      end
      S_STORE: begin
        bus.D_addr     = f_lo;
        bus.RF_Ra_addr = f_a;
        bus.D_wr       = 1'b1;
      end
      S_LDW, S_LDWR: begin
        bus.D_addr    = f_hi;
        bus.RF_s      = 2'd1;
        bus.RF_W_addr = f_w;
        bus.RF_W_en   = (state_q == S_LDWR);
      end
      S_ALU: begin
        bus.RF_Ra_addr = f_a;
        bus.RF_Rb_addr = f_b;
        bus.RF_W_addr  = f_w;
        bus.RF_W_en    = 1'b1;
        // ALU op comes from the opcode latched in DECODE, not the live IR
        bus.Alu_s = (op_q == OP_SUB) ? ALUW'(2) : ALUW'(1);
      end
      S_LDI: begin
        bus.Imm       = f_hi;
        bus.RF_s      = 2'd2;
        bus.RF_W_addr = f_w;
        bus.RF_W_en   = 1'b1;
      end
      S_JPZ: begin
        bus.RF_Ra_addr = f_a;
        bus.PC_addr    = f_lo;
        bus.PC_ld      = bus.Ra_zero;
      end
      S_HALT: bus.Halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.Illegal      = ill_q;
  assign bus.CurrentState = state_q;

endmodule
